if1_fetch_push: RTL and testbench

//  IF1 fetch front end; the producer side of the instruction buffer (IB). Keeps the fetch PC, issues
//  16-byte aligned block requests to the I-cache, and packs each response into up to 4 {pc,instr}

---
 rtl/if1_fetch_push_pkg.sv | 28 ++
 rtl/if1_fetch_push_if.sv | 40 ++++
 rtl/if1_fetch_push_fetch_block_align.sv | 31 +++
 rtl/if1_fetch_push.sv | 99 +++++++++
 tb/tb_if1_fetch_push.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/if1_fetch_push_pkg.sv
// Shared constants, FSM states and block-address helpers for the IF1 fetch front end.
package if1_fetch_push_pkg;

  localparam int unsigned IB_WIDTH       = 16;
  localparam int unsigned IB_WIDTH_LOG2  = 4;
  localparam int unsigned IB_DATA_BUS_WD = 64;
  localparam int unsigned PC_LSB         = 32;
  localparam int unsigned INSTR_LSB      = 0;
  localparam int unsigned FETCH_W        = 4;
  localparam int unsigned BLK_DATA_W     = 32 * FETCH_W;
  localparam logic [31:0] DEF_RESET_PC   = 32'h1c00_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] blk_addr(input logic [31:0] pc);
    return {pc[31:4], 4'b0000};
  endfunction

  // Next 16-byte block; the 28-bit add wraps naturally at 2^32.
  function automatic logic [31:0] next_blk_addr(input logic [31:0] pc);
    return {pc[31:4] + 28'd1, 4'b0000};
  endfunction

endpackage

// File: rtl/if1_fetch_push_if.sv
// I-cache request/response and IB push bus between the fetch front end (master) and its peers (slave).
interface if1_fetch_push_if
  import if1_fetch_push_pkg::*;
#(
  parameter int unsigned IB_SZ_W  = IB_WIDTH_LOG2 + 1,
  parameter int unsigned ENTRY_WD = IB_DATA_BUS_WD
);

  logic                      ic_req_valid;
  logic [31:0]               ic_req_addr;
  logic                      ic_req_ready;
  logic                      ic_resp_valid;
  logic [BLK_DATA_W-1:0]     ic_resp_data;
  logic [IB_SZ_W-1:0]        if_bf_sz;
  logic [2:0]                push_num;
  logic [FETCH_W*ENTRY_WD-1:0] if1_to_ib;

  modport master (
    output ic_req_valid,
    output ic_req_addr,
    input  ic_req_ready,
    input  ic_resp_valid,
    input  ic_resp_data,
    input  if_bf_sz,
    output push_num,
    output if1_to_ib
  );

  modport slave (
    input  ic_req_valid,
    input  ic_req_addr,
    output ic_req_ready,
    output ic_resp_valid,
    output ic_resp_data,
    output if_bf_sz,
    input  push_num,
    input  if1_to_ib
  );

endinterface

// File: rtl/if1_fetch_push_fetch_block_align.sv
// Packs a 16-byte I-cache block into up to four {pc,instr} IB entries starting at word offset i_off.
module fetch_block_align
  import if1_fetch_push_pkg::*;
#(
  parameter int unsigned ENTRY_WD = IB_DATA_BUS_WD
) (
  input  logic [BLK_DATA_W-1:0]         i_blk_data,
  input  logic [31:0]                   i_blk_addr,
  input  logic [1:0]                    i_off,
  output logic [2:0]                    o_push_num,
  output logic [FETCH_W*ENTRY_WD-1:0]   o_entries
);

  logic [2:0] w_idx;

  assign o_push_num = 3'd4 - {1'b0, i_off};

  // Lane j carries word (off+j); lanes past the end of the block stay zero.
  always_comb begin
    o_entries = '0;
    w_idx     = '0;
    for (int unsigned j = 0; j < FETCH_W; j++) begin
      w_idx = {1'b0, i_off} + 3'(j);
      if (w_idx < 3'd4) begin
        o_entries[j*ENTRY_WD + INSTR_LSB +: 32] = i_blk_data[w_idx[1:0]*32 +: 32];
        o_entries[j*ENTRY_WD + PC_LSB    +: 32] = i_blk_addr + {28'd0, w_idx[1:0], 2'b00};
      end
    end
  end

endmodule

// File: rtl/if1_fetch_push.sv
// IF1 fetch front end: holds the fetch PC, issues one block request at a time under IB credit,
// and pushes the aligned response into the instruction buffer; flush redirects and drops stale data.
module if1_fetch_push
  import if1_fetch_push_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned IB_DEPTH = IB_WIDTH,
  parameter int unsigned IB_SZ_W  = IB_WIDTH_LOG2 + 1,
  parameter int unsigned ENTRY_WD = IB_DATA_BUS_WD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  if1_fetch_push_if.master   bus,
  output logic [31:0]        fetch_pc
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  w_pc_nxt;
  logic         w_credit_ok;
  logic         w_req_valid;
  logic         w_push;
  logic [31:0]  w_req_addr;
  logic [2:0]   w_align_num;
  logic [FETCH_W*ENTRY_WD-1:0] w_align_entries;

  // Only one request is ever outstanding, so a full block of free slots is the whole credit test.
  assign w_credit_ok = (bus.if_bf_sz <= IB_SZ_W'(IB_DEPTH - FETCH_W));
  assign w_req_addr  = blk_addr(r_fetch_pc);

  fetch_block_align #(
    .ENTRY_WD (ENTRY_WD)
  ) u_align (
    .i_blk_data (bus.ic_resp_data),
    .i_blk_addr (w_req_addr),
    .i_off      (r_fetch_pc[3:2]),
    .o_push_num (w_align_num),
    .o_entries  (w_align_entries)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_REQ;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_fetch_pc;
    w_req_valid = 1'b0;
    w_push      = 1'b0;
    unique case (r_state)
      ST_REQ: begin
        // rst is folded in so the request drops the instant reset asserts.
        w_req_valid = w_credit_ok & ~flush & ~rst;
        if (flush) begin
          w_pc_nxt = flush_pc;
        end else if (w_req_valid && bus.ic_req_ready) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          w_pc_nxt    = flush_pc;
          w_state_nxt = bus.ic_resp_valid ? ST_REQ : ST_DROP;
        end else if (bus.ic_resp_valid) begin
          w_push      = 1'b1;
          w_pc_nxt    = next_blk_addr(r_fetch_pc);
          w_state_nxt = ST_REQ;
        end
      end
      ST_DROP: begin
        if (flush) begin
          w_pc_nxt = flush_pc;
        end
        if (bus.ic_resp_valid) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_REQ;
      end
    endcase
  end

  assign bus.ic_req_valid = w_req_valid;
  assign bus.ic_req_addr  = w_req_addr;
  assign bus.push_num     = w_push ? w_align_num : 3'd0;
  assign bus.if1_to_ib    = w_push ? w_align_entries : '0;
  assign fetch_pc         = r_fetch_pc;

endmodule

// File: tb/tb_if1_fetch_push.sv
// Directed and random stimulus for if1_fetch_push against a request/stale-flag reference model.
module tb_if1_fetch_push;
  import if1_fetch_push_pkg::*;

  localparam logic [31:0] RPC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] fetch_pc;

  if1_fetch_push_if #(.IB_SZ_W(5), .ENTRY_WD(64)) bus ();

  if1_fetch_push #(
    .RESET_PC (RPC),
    .IB_DEPTH (16),
    .IB_SZ_W  (5),
    .ENTRY_WD (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .flush_pc (flush_pc),
    .bus      (bus),
    .fetch_pc (fetch_pc)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: PC, whether a request is outstanding, and whether it has been orphaned by a flush.
  logic [31:0] m_pc;
  bit          m_busy;
  bit          m_stale;

  function automatic logic [255:0] exp_entries(input logic [31:0] pc, input logic [127:0] data);
    logic [255:0] e;
    int           off;
    logic [31:0]  a;
    e   = '0;
    off = int'(pc[3:2]);
    for (int j = 0; j < 4 - off; j++) begin
      a = (pc & 32'hffff_fff0) + 32'(4 * (off + j));
      e[j*64 +: 64] = {a, data[32*(off+j) +: 32]};
    end
    return e;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RPC;
    m_busy  = 1'b0;
    m_stale = 1'b0;
  endtask

  // One clock: check all outputs against the model mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit           ev;
    logic [2:0]   en;
    logic [255:0] ee;
    @(negedge clk);
    ev = !rst && !m_busy && !flush && (int'(bus.if_bf_sz) <= 12);
    chk("req_valid", bus.ic_req_valid, ev);
    if (ev) chk("req_addr", bus.ic_req_addr, m_pc & 32'hffff_fff0);
    chk("fetch_pc", fetch_pc, m_pc);
    if (m_busy && !m_stale && bus.ic_resp_valid && !flush) begin
      en = 3'(4 - int'(m_pc[3:2]));
      ee = exp_entries(m_pc, bus.ic_resp_data);
    end else begin
      en = 3'd0;
      ee = '0;
    end
    chk("push_num", bus.push_num, en);
    chk("if1_to_ib", bus.if1_to_ib, ee);
    @(posedge clk);
    if (flush) begin
      m_pc = flush_pc;
      if (m_busy) begin
        if (bus.ic_resp_valid) begin
          m_busy  = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
    end else if (m_busy && bus.ic_resp_valid) begin
      if (!m_stale) m_pc = (m_pc & 32'hffff_fff0) + 32'd16;
      m_busy  = 1'b0;
      m_stale = 1'b0;
    end else if (ev && bus.ic_req_ready) begin
      m_busy = 1'b1;
    end
    #1;
  endtask

  logic [127:0] d;

  initial begin
    rst                = 1'b1;
    flush              = 1'b0;
    flush_pc           = '0;
    bus.ic_req_ready   = 1'b1;
    bus.ic_resp_valid  = 1'b0;
    bus.ic_resp_data   = '0;
    bus.if_bf_sz       = '0;
    model_reset();
    #2;
    chk("rst_valid", bus.ic_req_valid, 1'b0);
    chk("rst_push", bus.push_num, 3'd0);
    chk("rst_ib", bus.if1_to_ib, '0);
    chk("rst_pc", fetch_pc, RPC);
    @(posedge clk); #1;
    rst = 1'b0;

    // Aligned start: full block of four.
    #1 chk("t1_addr", bus.ic_req_addr, 32'h1c00_0000);
    tick();
    d = rand128();
    bus.ic_resp_valid = 1'b1; bus.ic_resp_data = d;
    #1 chk("t1_push", bus.push_num, 3'd4);
    chk("t1_e3_pc", bus.if1_to_ib[255:224], 32'h1c00_000c);
    tick();
    bus.ic_resp_valid = 1'b0;
    #1 chk("t1_next", bus.ic_req_addr, 32'h1c00_0010);

    // Flush in REQ to a mid-block PC: two entries.
    flush = 1'b1; flush_pc = 32'h1c00_0028;
    #1 chk("t2_wd", bus.ic_req_valid, 1'b0);
    tick();
    flush = 1'b0;
    #1 chk("t2_addr", bus.ic_req_addr, 32'h1c00_0020);
    tick();
    d = rand128();
    bus.ic_resp_valid = 1'b1; bus.ic_resp_data = d;
    #1 chk("t2_push", bus.push_num, 3'd2);
    chk("t2_e0", bus.if1_to_ib[63:0], {32'h1c00_0028, d[95:64]});
    chk("t2_e1", bus.if1_to_ib[127:64], {32'h1c00_002c, d[127:96]});
    tick();
    bus.ic_resp_valid = 1'b0;

    // Credit threshold.
    bus.if_bf_sz = 5'd13;
    #1 chk("t3_full", bus.ic_req_valid, 1'b0);
    tick();
    bus.if_bf_sz = 5'd12;
    #1 chk("t3_ok", bus.ic_req_valid, 1'b1);
    tick();

    // Flush in WAIT; stale response three cycles later is dropped.
    flush = 1'b1; flush_pc = 32'h1c00_0100;
    tick();
    flush = 1'b0;
    tick();
    tick();
    bus.ic_resp_valid = 1'b1; bus.ic_resp_data = rand128();
    #1 chk("t4_drop", bus.push_num, 3'd0);
    tick();
    bus.ic_resp_valid = 1'b0;
    #1 chk("t4_next", bus.ic_req_addr, 32'h1c00_0100);

    // Flush coincident with response.
    tick();
    bus.ic_resp_valid = 1'b1; bus.ic_resp_data = rand128();
    flush = 1'b1; flush_pc = 32'h1c00_0200;
    #1 chk("t5_push", bus.push_num, 3'd0);
    tick();
    bus.ic_resp_valid = 1'b0; flush = 1'b0;
    #1 chk("t5_valid", bus.ic_req_valid, 1'b1);
    chk("t5_addr", bus.ic_req_addr, 32'h1c00_0200);

    // Top-of-address-space wrap.
    flush = 1'b1; flush_pc = 32'hffff_fff0;
    tick();
    flush = 1'b0;
    tick();
    bus.ic_resp_valid = 1'b1; bus.ic_resp_data = rand128();
    #1 chk("t6_push", bus.push_num, 3'd4);
    tick();
    bus.ic_resp_valid = 1'b0;
    #1 chk("t6_wrap", bus.ic_req_addr, 32'h0000_0000);

    // Asynchronous reset while waiting for a response.
    tick();
    bus.ic_resp_valid = 1'b1; bus.ic_resp_data = rand128();
    rst = 1'b1;
    #1;
    chk("ar_valid", bus.ic_req_valid, 1'b0);
    chk("ar_push", bus.push_num, 3'd0);
    chk("ar_ib", bus.if1_to_ib, '0);
    chk("ar_pc", fetch_pc, RPC);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.ic_resp_valid = 1'b0;
    model_reset();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.ic_req_ready  = 1'($urandom_range(0, 1));
      bus.if_bf_sz      = 5'($urandom_range(0, 16));
      bus.ic_resp_valid = m_busy && ($urandom_range(0, 2) == 0);
      bus.ic_resp_data  = rand128();
      flush             = ($urandom_range(0, 11) == 0);
      flush_pc          = $urandom() & 32'hffff_fffc;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
